// File: rtl/intr_arbiter.sv
// Interrupt arbiter: sticky pending register, mask, lowest-index priority, offer/ack handshake and
// blocking-timeout cause. Define INTR_STATS_EN to enable the accepted-ack counter on o_ack_count.
module intr_arbiter #(
   parameter int              NSRC          = 32,
   parameter int              TMO_BIT       = 26,
   parameter int              BLOCK_TIMEOUT = 1024,
   parameter logic [NSRC-1:0] NMI_MASK      = 32'h0000_0001
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NSRC-1:0]         i_req,
   input  logic                    i_mask_we,
   input  logic [NSRC-1:0]         i_mask,
   input  logic                    i_clr,
   input  logic                    i_block,
   input  logic                    i_ack,
   output logic                    o_irq,
   output logic [$clog2(NSRC)-1:0] o_vec,
   output logic [NSRC-1:0]         o_pending,
   output logic [NSRC-1:0]         o_mask,
   output logic [15:0]             o_ack_count
);
   localparam int          VW       = $clog2(NSRC);
   localparam logic [15:0] TMO_LAST = 16'(BLOCK_TIMEOUT - 1);
   localparam logic [NSRC-1:0] ONE  = {{(NSRC-1){1'b0}}, 1'b1};

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   state_t          state_q;
   logic            irq_q;
   logic [VW-1:0]   vec_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q;
   logic [15:0]     tmo_cnt_q;
   logic            fired_q;

   logic [NSRC-1:0] eligible, ackclr, tmo_set;
   logic            ack_take, tmo_fire, any_elig;
   logic [VW-1:0]   prio_idx;

   assign ack_take = i_ack & irq_q;
   assign ackclr   = ack_take ? (ONE << vec_q) : '0;
   assign tmo_fire = i_block & ~fired_q & (tmo_cnt_q == TMO_LAST);
   assign tmo_set  = tmo_fire ? (ONE << TMO_BIT) : '0;

   // Set beats both the ack clear and i_clr on the same edge.
   assign pending_d = (pending_q & ~ackclr & ~{NSRC{i_clr}}) | i_req | tmo_set;
   assign eligible  = pending_q & (mask_q | NMI_MASK);
   assign any_elig  = |eligible;

   always_comb begin
      prio_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) prio_idx = VW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         irq_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_elig) begin
                  state_q <= S_OFFER;
                  irq_q   <= 1'b1;
                  vec_q   <= prio_idx;
               end
            end
            S_OFFER: begin
               // Vector is frozen; leave on ack or when the offered cause is no longer eligible.
               if (i_ack || !eligible[vec_q]) begin
                  state_q <= S_IDLE;
                  irq_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (i_mask_we) mask_q <= i_mask;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
         fired_q   <= 1'b0;
      end else begin
         if (!i_block || i_clr)
            tmo_cnt_q <= '0;
         else if (!fired_q && tmo_cnt_q != 16'hFFFF)
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
         if (!i_block)
            fired_q <= 1'b0;
         else if (tmo_fire)
            fired_q <= 1'b1;
      end
   end

`ifdef INTR_STATS_EN
   logic [15:0] ack_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ack_cnt_q <= '0;
      else if (ack_take)
         ack_cnt_q <= ack_cnt_q + 16'd1;
   end

   assign o_ack_count = ack_cnt_q;
`else
   assign o_ack_count = '0;
`endif

   assign o_irq     = irq_q;
   assign o_vec     = vec_q;
   assign o_pending = pending_q;
   assign o_mask    = mask_q;
endmodule

// File: tb/tb_intr_arbiter.sv
// Scoreboard bench for intr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_intr_arbiter;
   localparam int          BT  = 8;
   localparam int          TMO = 26;
   localparam logic [31:0] NMI = 32'h0000_0001;
`ifdef INTR_STATS_EN
   localparam int ACK3 = 3;
`else
   localparam int ACK3 = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] i_req = '0;
   logic        i_mask_we = 1'b0;
   logic [31:0] i_mask = '0;
   logic        i_clr = 1'b0;
   logic        i_block = 1'b0;
   logic        i_ack = 1'b0;
   logic        o_irq;
   logic [4:0]  o_vec;
   logic [31:0] o_pending;
   logic [31:0] o_mask;
   logic [15:0] o_ack_count;

   always #5 clk = ~clk;

   intr_arbiter #(.BLOCK_TIMEOUT(BT)) dut (
      .clk(clk), .reset(reset), .i_req(i_req), .i_mask_we(i_mask_we), .i_mask(i_mask),
      .i_clr(i_clr), .i_block(i_block), .i_ack(i_ack), .o_irq(o_irq), .o_vec(o_vec),
      .o_pending(o_pending), .o_mask(o_mask), .o_ack_count(o_ack_count)
   );

   typedef struct {
      logic        irq;
      logic [4:0]  vec;
      logic [31:0] pend;
      logic [31:0] mask;
      logic [15:0] acks;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   logic [31:0] m_pend, m_mask;
   bit          m_offer, m_fired;
   int          m_vec, m_run, m_acks;

   function automatic int lowest(input logic [31:0] x);
      for (int i = 0; i < 32; i++) if (x[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_offer = 0; m_fired = 0;
      m_vec = 0; m_run = 0; m_acks = 0;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by one edge and queue the expected outputs.
   task automatic step(input logic [31:0] req, input bit we, input logic [31:0] mval,
                       input bit clr, input bit blk, input bit ack);
      exp_t e;
      logic [31:0] elig, pn;
      bit acc, tmo;
      @(negedge clk);
      i_req = req; i_mask_we = we; i_mask = mval; i_clr = clr; i_block = blk; i_ack = ack;
      acc  = ack && m_offer;
      elig = m_pend & (m_mask | NMI);
      tmo  = blk && !m_fired && (m_run == BT - 1);
      pn   = clr ? 32'h0 : m_pend;
      if (acc) pn[m_vec] = 1'b0;
      pn = pn | req;
      if (tmo) pn[TMO] = 1'b1;
      if (acc) $display("[TB] ack vec=%0d at %0t", m_vec, $time);
      if (m_offer) begin
         if (acc || !elig[m_vec]) m_offer = 0;
      end else if (elig != 0) begin
         m_offer = 1;
         m_vec   = lowest(elig);
      end
      if (!blk || clr) m_run = 0;
      else if (!m_fired) m_run = m_run + 1;
      if (!blk) m_fired = 0;
      else if (tmo) m_fired = 1;
      if (we) m_mask = mval;
`ifdef INTR_STATS_EN
      if (acc) m_acks = (m_acks + 1) % 65536;
`endif
      m_pend = pn;
      e.irq = m_offer; e.vec = 5'(m_vec); e.pend = m_pend; e.mask = m_mask; e.acks = 16'(m_acks);
      sb.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: pop and compare every cycle an expectation is outstanding.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp("irq", 32'(o_irq), 32'(e.irq));
            if (e.irq) cmp("vec", 32'(o_vec), 32'(e.vec));
            cmp("pending", o_pending, e.pend);
            cmp("mask", o_mask, e.mask);
            cmp("ack_count", 32'(o_ack_count), 32'(e.acks));
         end
      end
   end

   initial begin
      logic [31:0] r, mv;
      bit we, clr, blk, ack;
      int guard;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Priority: 3 before 10, one idle cycle between offers
      step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      step(32'h0000_0408, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("pri_irq_a", 32'(o_irq), 1); cmp("pri_vec3", 32'(o_vec), 3);
      step(0, 0, 0, 0, 0, 1); settle();
      cmp("pri_gap", 32'(o_irq), 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("pri_vec10", 32'(o_vec), 10);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("pri_done", 32'(o_irq), 0);

      // Freeze: vec 7 held while bit 2 arrives
      step(32'h80, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(32'h4, 0, 0, 0, 0, 0); settle();
      cmp("frz_vec7", 32'(o_vec), 7);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("frz_vec2", 32'(o_vec), 2);
      step(0, 0, 0, 0, 0, 1);

      // Masking: NMI bit 0 passes mask=0, bit 4 waits for its mask bit
      step(0, 1, 32'h0, 0, 0, 0);
      step(32'h1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("nmi_irq", 32'(o_irq), 1); cmp("nmi_vec", 32'(o_vec), 0);
      step(0, 0, 0, 0, 0, 1);
      step(32'h10, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("msk_irq0", 32'(o_irq), 0); cmp("msk_pend", o_pending, 32'h10);
      step(0, 1, 32'h10, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("msk_vec4", 32'(o_vec), 4);
      step(0, 0, 0, 0, 0, 1);

      // Ack/set collision on bit 9
      step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      step(32'h200, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(32'h200, 0, 0, 0, 0, 1); settle();
      cmp("col_gap", 32'(o_irq), 0); cmp("col_pend9", 32'(o_pending[9]), 1);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("col_vec9", 32'(o_vec), 9);
      step(0, 0, 0, 0, 0, 1);

      // Blocking timeout: fires once, on the BT-th blocked cycle
      step(0, 0, 0, 1, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         step(0, 0, 0, 0, 1, i == 10);
         settle();
         cmp($sformatf("tmo_run_%0d", i), 32'(o_pending[TMO]), 32'((i == 8) || (i == 9)));
      end
      step(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 0);
      settle();
      cmp("tmo_short", 32'(o_pending[TMO]), 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, 0, 1, 0);
         settle();
         cmp($sformatf("tmo_restart_%0d", i), 32'(o_pending[TMO]), 32'(i == 8));
      end
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);

      // Asynchronous reset mid-offer
      step(32'h20, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); settle();
      cmp("rst_pre_vec5", 32'(o_vec), 5);
      #1 reset = 1'b0;
      #1;
      cmp("rst_irq", 32'(o_irq), 0); cmp("rst_vec", 32'(o_vec), 0);
      cmp("rst_pend", o_pending, 0); cmp("rst_mask", o_mask, 0);
      cmp("rst_acks", 32'(o_ack_count), 0);
      model_reset();
      @(negedge clk);
      i_req = '0; i_mask_we = 0; i_mask = '0; i_clr = 0; i_block = 0; i_ack = 0;
      reset = 1'b1;

      // Ack counter: three acks, unaffected by i_clr
      step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(32'h2, 0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 1);
      end
      settle();
      cmp("stats_3", 32'(o_ack_count), ACK3);
      step(0, 0, 0, 1, 0, 0); settle();
      cmp("stats_clr", 32'(o_ack_count), ACK3);

      // Random traffic
      blk = 0;
      for (int k = 0; k < 1500; k++) begin
         r   = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
         we  = ($urandom_range(0, 15) == 0);
         mv  = $urandom;
         clr = ($urandom_range(0, 31) == 0);
         ack = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 19) == 0) blk = !blk;
         step(r, we, mv, clr, blk, ack);
      end

      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
Interrupt request arbiter that sits directly upstream of the CPU microsequencer's interrupt dispatch. It latches the 32 interrupt causes into a sticky pending register, applies a mask, and picks the highest-priority unmasked cause. It then presents a 5-bit vector to the microsequencer, which uses that vector to index intrtab[0..31]. The block also generates the "time-out during external interrupt blocking" cause (int27) from its own cycle counter.

Parameters:
NSRC, 32, number of interrupt sources; vector width is 5.
TMO_BIT, 26, pending bit set by the blocking timeout (intrtab index of int27).
BLOCK_TIMEOUT, 1024, consecutive i_block cycles that raise TMO_BIT; legal range 1..65535.
NMI_MASK, 32'h0000_0001, sources that ignore the mask register.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous reset, active-low
i_req  input  32  per-source request; a high level in a cycle sets that pending bit
i_mask_we  input  1  mask register write strobe
i_mask  input  32  new mask value; 1 = enabled
i_clr  input  1  synchronous clear of all pending bits and of the timeout counter
i_block  input  1  external interrupts blocked by the microprogram
i_ack  input  1  microsequencer accepted the current vector
o_irq  output  1  an interrupt is offered
o_vec  output  5  index of the offered interrupt
o_pending  output  32  raw pending register, for microcode reads
o_mask  output  32  current mask register
o_ack_count  output  16  acknowledged-interrupt counter (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous) values:
  - pending=0, mask=0, o_irq=0, o_vec=0, o_ack_count=0.
  - Timeout counter=0, fired flag=0.
- Pending update per edge: pending_next = (pending & ~ackclr & ~{32{i_clr}}) | i_req | tmo_set.
  - ackclr is a one-hot of o_vec, active only when i_ack=1 and o_irq=1.
  - Set wins over ack for the same bit on the same edge: the bit stays pending.
  - i_clr has priority over the ack clear, but new i_req and tmo_set bits in the same cycle still set.
- Eligible set = pending & (mask | NMI_MASK). Priority: the lowest index wins.
- Offer state machine, two states:
  - IDLE: o_irq=0. If eligible != 0 at an edge, load o_vec = priority index, set o_irq=1, go to OFFER. Latency is one cycle from a pending bit becoming eligible to o_irq=1.
  - OFFER: o_irq=1. o_vec is frozen, even if a higher-priority source arrives.
    - i_ack=1: clear that pending bit, go to IDLE. o_irq=0 for at least one cycle; back-to-back offers are separated by one idle cycle.
    - The pending bit was cleared by i_clr, or its mask was removed and it is not NMI: withdraw, o_irq=0, go to IDLE.
- i_ack while o_irq=0 is ignored.
- Mask write: mask takes i_mask at the edge; eligibility uses the new mask from the next cycle. o_mask is combinational from the register.
- Blocking timeout counter:
  - Increments each cycle i_block=1 and the fired flag is clear.
  - Cleared when i_block=0 or i_clr=1. Saturates; no wrap.
  - When the count reaches BLOCK_TIMEOUT-1 with i_block=1: tmo_set sets TMO_BIT on that edge, and the fired flag is set.
  - It fires once per blocking episode; the fired flag is cleared when i_block drops.
- The mask does not gate pending capture: masked sources accumulate and are offered once unmasked.

Optional Feature:
INTR_STATS_EN
- Defined: o_ack_count increments by 1 on every accepted ack (i_ack=1 with o_irq=1) and wraps 16'hFFFF -> 0. It is cleared only by reset, not by i_clr.
- Undefined: the counter logic is removed and o_ack_count is tied to 0.

Test Plan:
- Reset sequencing: reset=0 mid-offer with o_irq=1, vec=5 -> o_irq=0, o_vec=0, pending=0 immediately, with no clock edge required.
- Priority: mask=FFFFFFFF; i_req=32'h0000_0408 for one cycle -> next cycle o_irq=1, vec=3. After ack -> one idle cycle, then vec=10, ack, then o_irq stays 0.
- Freeze and masking: offering vec=7, then i_req bit 2 -> o_vec stays 7 until ack, then vec=2. With mask=0, i_req bit 0 -> offered (NMI); i_req bit 4 -> pending=32'h10, o_irq=0 until mask bit 4 is written.
- Ack/set collision: offering vec=9, i_ack=1 and i_req[9]=1 on the same edge -> pending[9] stays 1, o_irq drops for one cycle, then vec=9 again.
- Timeout: BLOCK_TIMEOUT=8, i_block=1 for 20 cycles -> pending[26] set exactly once, on the 8th cycle. Dropping i_block at cycle 5 and reasserting it restarts the count.
- INTR_STATS_EN defined: 3 acks -> o_ack_count=3; an i_clr -> count still 3.
